// File: rtl/sa_pkg.sv
// Shared definitions for the 2x2 weight-stationary array: geometry, skew and
// the result-vector layout used by the feeder, drain and tile controller.
package sa_pkg;
   localparam int SA_DATA_W   = 8;
   localparam int SA_DIM      = 2;
   localparam int SA_COL_SKEW = 1;  // cycles column c+1 lags column c

   typedef struct packed {
      logic                 last;
      logic [SA_DATA_W-1:0] data2;
      logic [SA_DATA_W-1:0] data1;
   } sa_vec_t;
endpackage

// File: rtl/sa2x2_drain_if.sv
// Psum-side bundle of the drain: array inputs, downstream handshake and status.
interface sa2x2_drain_if
   import sa_pkg::*;
#(
   parameter int DATA_W = SA_DATA_W
);
   logic              col_valid;
   logic [DATA_W-1:0] psum_in1;
   logic [DATA_W-1:0] psum_in2;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data1;
   logic [DATA_W-1:0] out_data2;
   logic              out_last;
   logic              almost_full;
   logic              overflow;

   modport master (
      output col_valid, psum_in1, psum_in2, out_ready,
      input  out_valid, out_data1, out_data2, out_last, almost_full, overflow
   );

   modport slave (
      input  col_valid, psum_in1, psum_in2, out_ready,
      output out_valid, out_data1, out_data2, out_last, almost_full, overflow
   );
endinterface

// File: rtl/sa_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push on full is taken
// when a pop frees the head on the same edge.
module sa_sync_fifo
   import sa_pkg::*;
#(
   parameter int WIDTH = 2*SA_DATA_W + 1,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/sa2x2_drain.sv
// Psum drain for the 2x2 array: de-skews column 2, tags tile boundaries and
// buffers result vectors; loss is flagged because the array cannot stall.
module sa2x2_drain
   import sa_pkg::*;
#(
   parameter int DATA_W    = SA_DATA_W,
   parameter int DEPTH     = 4,
   parameter int TILE_LEN  = 4,
   parameter int AF_MARGIN = 2
) (
   input logic         clk,
   input logic         rst,
   input logic         clear,
   sa2x2_drain_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
   localparam int FW = 2*DATA_W + 1;

   logic              flush;
   logic [DATA_W-1:0] hold_q;
   logic              pend_q;
   logic [CW-1:0]     vcnt_q;
   logic              af_q, ovf_q;

   logic              empty, full, pop, push, drop, last;
   logic [AW:0]       count, cnt_d;
   logic [FW-1:0]     wdata, rdata;

   assign flush = rst || clear;
   assign last  = (vcnt_q == CW'(TILE_LEN-1));
   assign wdata = {last, bus.psum_in2, hold_q};
   assign pop   = !empty && bus.out_ready;
   assign push  = pend_q && (!full || pop);
   assign drop  = pend_q && full && !pop;
   assign cnt_d = count + (AW+1)'(push) - (AW+1)'(pop);

   sa_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (flush),
      .push_i (push),
      .pop_i  (pop),
      .wdata_i(wdata),
      .rdata_o(rdata),
      .empty_o(empty),
      .full_o (full),
      .count_o(count)
   );

   // A clear drops the pending half-vector and realigns the tile count.
   always_ff @(posedge clk) begin
      if (flush) begin
         hold_q <= '0;
         pend_q <= 1'b0;
         vcnt_q <= '0;
         af_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= bus.col_valid;
         if (bus.col_valid) hold_q <= bus.psum_in1;
         if (pend_q) vcnt_q <= last ? '0 : vcnt_q + CW'(1);
         if (drop) ovf_q <= 1'b1;
         af_q <= (cnt_d >= (AW+1)'(DEPTH - AF_MARGIN));
      end
   end

   always_comb begin
      bus.out_valid = !empty;
      bus.out_data1 = '0;
      bus.out_data2 = '0;
      bus.out_last  = 1'b0;
      if (!empty) begin
         bus.out_data1 = rdata[DATA_W-1:0];
         bus.out_data2 = rdata[2*DATA_W-1:DATA_W];
         bus.out_last  = rdata[FW-1];
      end
   end

   assign bus.almost_full = af_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_sa2x2_drain.sv
// Scoreboard bench for sa2x2_drain: a queue model of the drain predicts the
// head vector and status each cycle under directed and random traffic.
module tb_sa2x2_drain;
   import sa_pkg::*;

   localparam int DEPTH     = 4;
   localparam int TILE_LEN  = 4;
   localparam int AF_MARGIN = 2;

   logic clk = 1'b0;
   logic rst, clear;
   always #5 clk = ~clk;

   sa2x2_drain_if #(.DATA_W(SA_DATA_W)) bus ();

   sa2x2_drain #(.DATA_W(SA_DATA_W), .DEPTH(DEPTH), .TILE_LEN(TILE_LEN),
                 .AF_MARGIN(AF_MARGIN)) dut (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .bus  (bus)
   );

   // Reference model: expected FIFO contents as a queue of result vectors.
   sa_vec_t        expq[$];
   bit             m_pend, m_ovf, m_af, chk_en;
   logic [7:0]     m_hold;
   int             m_vcnt;
   int             n_chk, n_pass;

   always @(posedge clk) begin : model
      bit      pop;
      sa_vec_t v;
      if (rst || clear) begin
         expq.delete();
         m_pend = 0; m_ovf = 0; m_af = 0; m_vcnt = 0; m_hold = '0;
         chk_en = 1;
      end else begin
         pop = (expq.size() != 0) && bus.out_ready;
         v = '0;
         if (m_pend) begin
            v.data1 = m_hold;
            v.data2 = bus.psum_in2;
            v.last  = (m_vcnt == TILE_LEN-1);
            m_vcnt  = (m_vcnt + 1) % TILE_LEN;
         end
         if (pop) void'(expq.pop_front());
         if (m_pend) begin
            if (expq.size() < DEPTH) expq.push_back(v);
            else m_ovf = 1;
         end
         m_pend = bus.col_valid;
         if (bus.col_valid) m_hold = bus.psum_in1;
         m_af = (expq.size() >= DEPTH - AF_MARGIN);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   always @(negedge clk) begin : monitor
      sa_vec_t h;
      if (chk_en) begin
         h = (expq.size() != 0) ? expq[0] : '0;
         check("out_valid",   32'(bus.out_valid),   32'(expq.size() != 0));
         check("out_data1",   32'(bus.out_data1),   32'(h.data1));
         check("out_data2",   32'(bus.out_data2),   32'(h.data2));
         check("out_last",    32'(bus.out_last),    32'(h.last));
         check("almost_full", 32'(bus.almost_full), 32'(m_af));
         check("overflow",    32'(bus.overflow),    32'(m_ovf));
      end
   end

   task automatic idle(input int n, input bit rdy, input bit clr);
      for (int i = 0; i < n; i++) begin
         bus.col_valid = 1'b0;
         bus.psum_in1  = 8'($urandom);
         bus.psum_in2  = 8'($urandom);
         bus.out_ready = rdy;
         clear         = clr;
         @(posedge clk); #1;
      end
      clear = 1'b0;
   endtask

   // n back-to-back vectors (b1+i, b2+i); column 2 lags by one cycle.
   task automatic stream(input int n, input logic [7:0] b1, input logic [7:0] b2, input bit rdy);
      for (int i = 0; i <= n; i++) begin
         bus.col_valid = (i < n);
         bus.psum_in1  = (i < n) ? 8'(b1 + 8'(i)) : 8'($urandom);
         bus.psum_in2  = (i > 0) ? 8'(b2 + 8'(i - 1)) : 8'($urandom);
         bus.out_ready = rdy;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      chk_en = 0; n_chk = 0; n_pass = 0;
      rst = 1'b1; clear = 1'b0;
      bus.col_valid = 1'b0; bus.psum_in1 = '0; bus.psum_in2 = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(3, 1'b0, 1'b0);

      // single vector through an empty FIFO
      stream(1, 8'h11, 8'h22, 1'b1);
      idle(3, 1'b1, 1'b0);

      // one tile plus a fifth vector
      idle(1, 1'b1, 1'b1);
      stream(4, 8'h01, 8'hA1, 1'b1);
      stream(1, 8'h05, 8'hA5, 1'b1);
      idle(3, 1'b1, 1'b0);

      // overflow with no draining, then drain
      idle(1, 1'b1, 1'b1);
      stream(6, 8'h01, 8'hA1, 1'b0);
      idle(2, 1'b0, 1'b0);
      idle(6, 1'b1, 1'b0);

      // full FIFO with a pop on the edge a vector completes
      idle(1, 1'b1, 1'b1);
      stream(4, 8'h31, 8'hC1, 1'b0);
      stream(2, 8'h41, 8'hD1, 1'b1);
      idle(6, 1'b1, 1'b0);

      // clear on the edge where a half-vector is pending
      bus.col_valid = 1'b1; bus.psum_in1 = 8'h77; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      idle(1, 1'b1, 1'b1);
      stream(4, 8'h51, 8'hE1, 1'b1);
      idle(3, 1'b1, 1'b0);

      // random traffic with occasional clears
      for (int c = 0; c < 600; c++) begin
         bus.col_valid = ($urandom_range(0, 9) < 7);
         bus.psum_in1  = 8'($urandom);
         bus.psum_in2  = 8'($urandom);
         bus.out_ready = ($urandom_range(0, 1) == 1);
         clear         = ($urandom_range(0, 99) < 2);
         rst           = ($urandom_range(0, 299) == 0);
         @(posedge clk); #1;
      end
      clear = 1'b0; rst = 1'b0;
      idle(8, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
